// File: rtl/arbitro_rr4_pkg.sv
// Shared constants for the 4-way round-robin arbiter:
// state encoding, channel/counter widths and a one-hot helper.
package arbitro_rr4_pkg;

  localparam int CH_W  = 2;
  localparam int CNT_W = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [3:0] onehot(input logic [CH_W-1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/arbitro_rr4_prio.sv
// prio_rr4: first set bit of vec at or after start, wrapping 3->0.
// Pure combinational; found is low when vec is empty.
module prio_rr4
  import arbitro_rr4_pkg::*;
(
  input  logic [3:0]      vec,
  input  logic [CH_W-1:0] start,
  output logic [CH_W-1:0] idx,
  output logic            found
);

  logic [CH_W-1:0] pos;

  // Walk from the farthest slot back to start so the nearest hit wins.
  always_comb begin
    idx   = '0;
    pos   = '0;
    found = |vec;
    for (int k = 3; k >= 0; k--) begin
      pos = start + CH_W'(k);
      if (vec[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/arbitro_rr4.sv
// 4-input round-robin arbiter driving a 4:1 mux select.
// Grants are held until done, request drop, or HOLD_MAX cycles.
module arbitro_rr4
  import arbitro_rr4_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [3:0]      req,
  input  logic            done,
  output logic [CH_W-1:0] s,
  output logic [3:0]      grant,
  output logic            valid
);

  logic [0:0]       state;
  logic [CH_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;

  logic             expire;
  logic             rel;
  logic [3:0]       others;
  logic [3:0]       pvec;
  logic [CH_W-1:0]  pstart;
  logic [CH_W-1:0]  pidx;
  logic             pfound;
  logic [CH_W-1:0]  s_nxt;

  assign s_nxt  = s + CH_W'(1);
  assign expire = (cnt == CNT_W'(HOLD_MAX - 1));
  assign others = req & ~onehot(s);
  assign rel    = (state == ST_GRANT)
                & (done | ~req[s] | expire);

  // In GRANT the search skips the current owner and starts after it.
  assign pvec   = (state == ST_GRANT) ? others : req;
  assign pstart = (state == ST_GRANT) ? s_nxt : ptr;

  prio_rr4 u_prio (
    .vec   (pvec),
    .start (pstart),
    .idx   (pidx),
    .found (pfound)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      s     <= '0;
      grant <= '0;
      valid <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pfound) begin
            state <= ST_GRANT;
            s     <= pidx;
            grant <= onehot(pidx);
            valid <= 1'b1;
            cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            ptr <= s_nxt;
            if (pfound) begin
              s     <= pidx;
              grant <= onehot(pidx);
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
              grant <= '0;
              valid <= 1'b0;
            end
          end else if (!expire) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_rr4.sv
// Bench for arbitro_rr4: four instances (HOLD_MAX 8,3,2,1) share
// stimulus and are checked every cycle against a behavioural model.
module tb_arbitro_rr4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;

  logic [1:0] s_o  [4];
  logic [3:0] gr_o [4];
  logic       v_o  [4];

  int cmp = 0;
  int bad = 0;

  int hm [4] = '{8, 3, 2, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int H = (g == 0) ? 8 : (g == 1) ? 3 : (g == 2) ? 2 : 1;
    arbitro_rr4 #(.HOLD_MAX(H)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .done    (done),
      .s       (s_o[g]),
      .grant   (gr_o[g]),
      .valid   (v_o[g])
    );
  end

  // Behavioural model: owner, pointer and held-cycle count per instance.
  bit m_act [4];
  int m_s   [4];
  int m_ptr [4];
  int m_cnt [4];

  function automatic int first_from(input logic [3:0] v, input int st);
    for (int k = 0; k < 4; k++)
      if (v[(st + k) % 4]) return (st + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 4; g++) begin
        m_act[g] = 0; m_s[g] = 0; m_ptr[g] = 0; m_cnt[g] = 0;
      end
    end else begin
      for (int g = 0; g < 4; g++) begin
        if (!m_act[g]) begin
          if (req != 0) begin
            m_s[g] = first_from(req, m_ptr[g]);
            m_act[g] = 1; m_cnt[g] = 0;
          end
        end else if (done || !req[m_s[g]] || m_cnt[g] == hm[g] - 1) begin
          logic [3:0] oth;
          oth = req;
          oth[m_s[g]] = 1'b0;
          m_ptr[g] = (m_s[g] + 1) % 4;
          if (oth != 0) begin
            m_s[g] = first_from(oth, m_ptr[g]);
            m_cnt[g] = 0;
          end else begin
            m_act[g] = 0;
          end
        end else begin
          m_cnt[g] = m_cnt[g] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      logic [6:0] a, e;
      a = {s_o[g], gr_o[g], v_o[g]};
      e[6:5] = 2'(m_s[g]);
      e[4:1] = m_act[g] ? (4'b0001 << m_s[g]) : 4'b0000;
      e[0]   = m_act[g];
      chk($sformatf("model_inst%0d", g), 32'(a), 32'(e));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = 4'b0000; done = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int exp28 [7] = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    // Reset state
    tick();
    chk("reset_s", 32'(s_o[0]), 0);
    chk("reset_grant", 32'(gr_o[0]), 0);
    chk("reset_valid", 32'(v_o[0]), 0);
    reset_n = 1'b1;

    // Single request after reset
    req = 4'b0100;
    tick();
    chk("single_s", 32'(s_o[0]), 2);
    chk("single_grant", 32'(gr_o[0]), 32'h4);
    chk("single_valid", 32'(v_o[0]), 1);

    // Round robin with done every second cycle
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rr_s_a", 32'(s_o[0]), 32'(i % 4));
      chk("rr_valid_a", 32'(v_o[0]), 1);
      done = 1'b0;
      tick();
      chk("rr_s_b", 32'(s_o[0]), 32'(i % 4));
      chk("rr_valid_b", 32'(v_o[0]), 1);
      done = 1'b1;
      tick();
    end
    done = 1'b0;

    // Hold limit, HOLD_MAX = 3
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("hold3_s", 32'(s_o[1]), 32'(exp28[i]));
      chk("hold3_valid", 32'(v_o[1]), 1);
    end

    // Request drop, then pointer check
    do_reset();
    req = 4'b0010;
    tick();
    chk("drop_s0", 32'(s_o[0]), 1);
    req = 4'b0000;
    tick();
    chk("drop_valid", 32'(v_o[0]), 0);
    chk("drop_grant", 32'(gr_o[0]), 0);
    chk("drop_s", 32'(s_o[0]), 1);
    req = 4'b0101;
    tick();
    chk("drop_ptr_s", 32'(s_o[0]), 2);
    chk("drop_ptr_valid", 32'(v_o[0]), 1);

    // Async reset mid-grant
    do_reset();
    req = 4'b1000;
    tick();
    chk("arst_pre_s", 32'(s_o[0]), 3);
    chk("arst_pre_valid", 32'(v_o[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v_o[0]), 0);
    chk("arst_s", 32'(s_o[0]), 0);
    chk("arst_grant", 32'(gr_o[0]), 0);
    tick();
    reset_n = 1'b1;

    // Simultaneous done and expiry, HOLD_MAX = 2
    do_reset();
    req = 4'b1001;
    tick();
    chk("simul_s0", 32'(s_o[2]), 0);
    tick();
    chk("simul_s1", 32'(s_o[2]), 0);
    done = 1'b1;
    tick();
    chk("simul_s", 32'(s_o[2]), 3);
    chk("simul_valid", 32'(v_o[2]), 1);
    done = 1'b0;

    // HOLD_MAX = 1 alternates every cycle
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold1_s", 32'(s_o[3]), 32'(i % 2));
      chk("hold1_valid", 32'(v_o[3]), 1);
    end

    // Other requests do not disturb an active grant
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b1111;
    tick();
    chk("stable_s", 32'(s_o[0]), 0);
    chk("stable_valid", 32'(v_o[0]), 1);

    // Randomized traffic, model checked on every negedge
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/arbitro_rr4.md
ARBITRO_RR4 -- requirements
Module: arbitro_rr4

Interface
REQ-001 Parameter HOLD_MAX, default 8, SHALL be the maximum number of consecutive cycles one grant is held (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req  input  4  SHALL carry one request line per mux data input (bit 0 = a, 1 = b, 2 = c, 3 = d).
REQ-005 done  input  1  SHALL signal, when high, that the current grantee has finished; it is ignored while valid is low.
REQ-006 s  output  2  SHALL drive the select input of the downstream 4:1 mux; it is registered.
REQ-007 grant  output  4  SHALL be the one-hot form of s while valid is high, and 0000 otherwise; it is registered.
REQ-008 valid  output  1  SHALL be high while a grant is active; it is registered.

Function
REQ-009 States SHALL be IDLE (no grant) and GRANT (one input selected).
REQ-010 In IDLE with req != 0000, the block SHALL pick the first set bit at or after pointer ptr, wrapping 3->0, and enter GRANT on the next edge; request-to-valid latency SHALL be 1 cycle.
REQ-011 In IDLE with req == 0000, the block SHALL stay in IDLE, keep valid = 0 and grant = 0000, and hold s at its last value.
REQ-012 In GRANT, a release SHALL occur on any of the following: done = 1; req[s] = 0; or hold counter == HOLD_MAX-1.
REQ-013 On release, ptr SHALL become s+1 modulo 4.
REQ-014 On release, if any req bit other than the current s is set, the block SHALL grant the next requester from the new ptr on the same edge, with no idle bubble.
REQ-015 On release, if no other req bit is set, the block SHALL return to IDLE; a still-asserted req[s] SHALL be regranted only through IDLE, one cycle later.
REQ-016 The hold counter SHALL clear on every new grant and increment each GRANT cycle without release; its width SHALL be 4 bits and it SHALL never wrap.
REQ-017 With HOLD_MAX = 1, every grant SHALL last exactly one cycle.
REQ-018 When done and a counter expiry coincide, the block SHALL treat them as a single release; ptr SHALL advance only once.
REQ-019 Changes on req bits other than s during GRANT SHALL NOT affect s or valid until a release.

Reset
REQ-020 While reset_n = 0: state = IDLE, s = 00, grant = 0000, valid = 0, ptr = 00, counter = 0.
REQ-021 Reset asserted mid-grant SHALL force outputs to reset values immediately, without waiting for clk.
REQ-022 After deassertion, the first grant SHALL be evaluated at the first rising clk edge.

Structure
REQ-023 A shared package SHALL hold the state encoding (IDLE = 0, GRANT = 1), the channel width constant (2), and the counter width (4).
REQ-024 One combinational sub-module, prio_rr4, SHALL select the first set bit of a 4-bit vector starting at a 2-bit pointer, returning index and a found flag.
REQ-025 All outputs SHALL come directly from flops; the block SHALL contain no combinational path from req or done to any output.

Verification
REQ-026 Single request after reset: req = 0100 at cycle 0 -> one cycle later s = 10, grant = 0100, valid = 1.
REQ-027 Round robin: req = 1111, done pulsed every 2nd cycle -> s sequence 00, 01, 10, 11, 00, with no cycle where valid = 0.
REQ-028 Hold limit: HOLD_MAX = 3, req = 0011, done = 0 -> s = 00 for 3 cycles, then s = 01 for 3 cycles, then s = 00.
REQ-029 Request drop: granted s = 01, req changes 0010 -> 0000 -> next edge valid = 0, grant = 0000, s stays 01; ptr = 10, checked by then raising req = 0101 and observing s = 10.
REQ-030 Async reset mid-grant: s = 11, valid = 1, reset_n pulled low between edges -> valid = 0, s = 00, grant = 0000 before the next clk edge.
REQ-031 Simultaneous release: HOLD_MAX = 2, done = 1 on the expiry cycle, req = 1001, s = 00 -> next s = 11 (not 00), with ptr advanced once.
